framebuf_sched: RTL and testbench

Frame-level scheduler for the frame-buffer memory interface, which sits between the camera input FIFO and the display output FIFO. It issues the flush that re-aligns the buffer at each camera start-of-frame and tracks pixel writes until a full frame is stored. It then issues the display request on each display vsync and tracks readout so that a frame is never displayed while partially written.

---
 rtl/framebuf_sched_if.sv | 24 ++
 rtl/framebuf_sched.sv | 146 ++++++++++++++
 tb/tb_framebuf_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/framebuf_sched_if.sv
// Frame-buffer scheduler event/control bundle: camera and display events in,
// memory-interface controls and status out.
interface framebuf_sched_if;
    logic       i_cam_sof;
    logic       i_pix_wr;
    logic       i_disp_vsync;
    logic       i_pix_rd;
    logic       o_flush;
    logic       o_req;
    logic       o_frame_valid;
    logic [2:0] o_state;
    logic [7:0] o_drop_cnt;
    logic [7:0] o_underrun_cnt;

    modport master (
        output i_cam_sof, i_pix_wr, i_disp_vsync, i_pix_rd,
        input  o_flush, o_req, o_frame_valid, o_state, o_drop_cnt, o_underrun_cnt
    );

    modport slave (
        input  i_cam_sof, i_pix_wr, i_disp_vsync, i_pix_rd,
        output o_flush, o_req, o_frame_valid, o_state, o_drop_cnt, o_underrun_cnt
    );
endinterface

// File: rtl/framebuf_sched.sv
// Frame-level flush/fill/display scheduler for the frame-buffer memory interface.
// Optional drop/underrun statistics are enabled by defining FRAMEBUF_SCHED_STATS_EN.
module framebuf_sched #(
    parameter int FRAME_PIXELS = 307200,
    parameter int FLUSH_CYCLES = 4,
    parameter int REQ_CYCLES   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    framebuf_sched_if.slave   bus
);
    localparam int CW   = $clog2(FRAME_PIXELS + 1);
    localparam int TMAX = (FLUSH_CYCLES > REQ_CYCLES) ? FLUSH_CYCLES : REQ_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        FILL    = 3'd2,
        READY   = 3'd3,
        REQ     = 3'd4,
        READOUT = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          go_flush, drop_inc, und_inc;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CW'(FRAME_PIXELS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        pend_d   = pend_q;
        go_flush = 1'b0;
        drop_inc = 1'b0;
        und_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                und_inc  = bus.i_disp_vsync;
                go_flush = bus.i_cam_sof;
            end
            FLUSH: begin
                cnt_d = '0;
                if (tmr_q == '0) state_d = FILL;
                else             tmr_d   = tmr_q - TW'(1);
            end
            FILL: begin
                und_inc = bus.i_disp_vsync;
                if (bus.i_cam_sof) begin
                    drop_inc = 1'b1;
                    go_flush = 1'b1;
                end else if (bus.i_pix_wr) begin
                    if (cnt_last) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            READY: begin
                // A restart beats a display request; the vsync then finds no frame.
                if (bus.i_cam_sof) begin
                    und_inc  = bus.i_disp_vsync;
                    go_flush = 1'b1;
                end else if (bus.i_disp_vsync) begin
                    state_d = REQ;
                    tmr_d   = TW'(REQ_CYCLES - 1);
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (bus.i_cam_sof) pend_d = 1'b1;
                if (tmr_q == '0) state_d = READOUT;
                else             tmr_d   = tmr_q - TW'(1);
            end
            READOUT: begin
                if (bus.i_cam_sof) pend_d = 1'b1;
                if (bus.i_pix_rd) begin
                    if (cnt_last) begin
                        cnt_d = '0;
                        if (pend_q || bus.i_cam_sof) go_flush = 1'b1;
                        else                         state_d  = READY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (go_flush) begin
            state_d = FLUSH;
            tmr_d   = TW'(FLUSH_CYCLES - 1);
            cnt_d   = '0;
            pend_d  = 1'b0;
        end
    end

    always_comb begin
        bus.o_state       = state_q;
        bus.o_flush       = (state_q == FLUSH);
        bus.o_req         = (state_q == REQ);
        bus.o_frame_valid = (state_q == READY) || (state_q == REQ) || (state_q == READOUT);
    end

`ifdef FRAMEBUF_SCHED_STATS_EN
    logic [7:0] drop_q, und_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_q <= '0;
            und_q  <= '0;
        end else begin
            if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (und_inc  && und_q  != 8'hFF) und_q  <= und_q  + 8'd1;
        end
    end

    assign bus.o_drop_cnt     = drop_q;
    assign bus.o_underrun_cnt = und_q;
`else
    logic stats_unused;
    assign stats_unused       = drop_inc | und_inc;
    assign bus.o_drop_cnt     = 8'd0;
    assign bus.o_underrun_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_framebuf_sched.sv
// Bench for framebuf_sched: directed scenarios with literal expectations, then
// random traffic, all checked each cycle against an event-level reference model.
module tb_framebuf_sched;
    localparam int FP  = 16;
    localparam int FLC = 4;
    localparam int RQC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    framebuf_sched_if bus ();

    framebuf_sched #(.FRAME_PIXELS(FP), .FLUSH_CYCLES(FLC), .REQ_CYCLES(RQC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle,1 flush,2 fill,3 ready,4 request,5 readout.
    int m_mode = 0, m_pix = 0, m_elapsed = 0, m_drop = 0, m_und = 0;
    bit m_pend = 0;

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    always @(posedge clk) begin
        bit sof, wr, vs, rd, restart;
        sof = bus.i_cam_sof; wr = bus.i_pix_wr; vs = bus.i_disp_vsync; rd = bus.i_pix_rd;
        restart = 0;
        if (rst) begin
            m_mode = 0; m_pix = 0; m_elapsed = 0; m_pend = 0; m_drop = 0; m_und = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (vs) m_und = sat(m_und);
                    restart = sof;
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == FLC) begin m_mode = 2; m_pix = 0; end
                end
                2: begin
                    if (vs) m_und = sat(m_und);
                    if (sof) begin m_drop = sat(m_drop); restart = 1; end
                    else if (wr) begin
                        m_pix++;
                        if (m_pix == FP) begin m_mode = 3; m_pix = 0; end
                    end
                end
                3: begin
                    if (sof) begin
                        if (vs) m_und = sat(m_und);
                        restart = 1;
                    end else if (vs) begin
                        m_mode = 4; m_elapsed = 0;
                    end
                end
                4: begin
                    if (sof) m_pend = 1;
                    m_elapsed++;
                    if (m_elapsed == RQC) begin m_mode = 5; m_pix = 0; end
                end
                default: begin
                    if (sof) m_pend = 1;
                    if (rd) begin
                        m_pix++;
                        if (m_pix == FP) begin
                            m_pix = 0;
                            if (m_pend) restart = 1;
                            else        m_mode = 3;
                        end
                    end
                end
            endcase
            if (restart) begin m_mode = 1; m_elapsed = 0; m_pix = 0; m_pend = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int exp_drop, exp_und;
`ifdef FRAMEBUF_SCHED_STATS_EN
            exp_drop = m_drop; exp_und = m_und;
`else
            exp_drop = 0; exp_und = 0;
`endif
            check("m_state", bus.o_state, m_mode);
            check("m_flush", bus.o_flush, m_mode == 1);
            check("m_req",   bus.o_req,   m_mode == 4);
            check("m_valid", bus.o_frame_valid, (m_mode >= 3) && (m_mode <= 5));
            check("m_drop",  bus.o_drop_cnt, exp_drop);
            check("m_und",   bus.o_underrun_cnt, exp_und);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_high(input bit use_req, output int n);
        n = 0;
        while ((use_req ? bus.o_req : bus.o_flush) && n < 50) begin
            n++;
            tick();
        end
    endtask

    int n;
    int stats_on;

    initial begin
`ifdef FRAMEBUF_SCHED_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        bus.i_cam_sof = 0; bus.i_pix_wr = 0; bus.i_disp_vsync = 0; bus.i_pix_rd = 0;
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        check("rst_state", bus.o_state, 0);
        check("rst_flush", bus.o_flush, 0);
        check("rst_req",   bus.o_req, 0);
        check("rst_valid", bus.o_frame_valid, 0);
        check("rst_drop",  bus.o_drop_cnt, 0);
        check("rst_und",   bus.o_underrun_cnt, 0);
        rst = 0;

        bus.i_cam_sof = 1; tick(); bus.i_cam_sof = 0;
        count_high(0, n);
        check("flush_len", n, 4);
        check("after_flush_state", bus.o_state, 2);
        bus.i_pix_wr = 1; repeat (FP - 1) tick();
        check("fill_almost_valid", bus.o_frame_valid, 0);
        tick(); bus.i_pix_wr = 0;
        check("fill_done_valid", bus.o_frame_valid, 1);
        check("fill_done_state", bus.o_state, 3);

        repeat (2) begin
            bus.i_disp_vsync = 1; tick(); bus.i_disp_vsync = 0;
            count_high(1, n);
            check("req_len", n, 4);
            check("req_then_readout", bus.o_state, 5);
            bus.i_pix_rd = 1; repeat (FP) tick(); bus.i_pix_rd = 0;
            check("readout_done_state", bus.o_state, 3);
        end

        bus.i_cam_sof = 1; tick(); bus.i_cam_sof = 0;
        count_high(0, n);
        bus.i_pix_wr = 1; repeat (10) tick(); bus.i_pix_wr = 0;
        bus.i_cam_sof = 1; tick(); bus.i_cam_sof = 0;
        check("drop_state", bus.o_state, 1);
        check("drop_cnt", bus.o_drop_cnt, stats_on);
        count_high(0, n);
        check("reflush_len", n, 4);
        bus.i_pix_wr = 1; repeat (FP - 1) tick();
        check("refill_not_done", bus.o_state, 2);
        tick(); bus.i_pix_wr = 0;
        check("refill_done", bus.o_state, 3);

        bus.i_disp_vsync = 1; tick(); bus.i_disp_vsync = 0;
        count_high(1, n);
        bus.i_pix_rd = 1; repeat (5) tick();
        bus.i_cam_sof = 1; tick(); bus.i_cam_sof = 0;
        repeat (FP - 7) tick();
        check("pend_no_flush", bus.o_flush, 0);
        check("pend_state", bus.o_state, 5);
        tick(); bus.i_pix_rd = 0;
        check("pend_flush", bus.o_flush, 1);
        check("pend_valid", bus.o_frame_valid, 0);

        count_high(0, n);
        bus.i_pix_wr = 1; repeat (FP) tick(); bus.i_pix_wr = 0;
        bus.i_disp_vsync = 1; tick(); bus.i_disp_vsync = 0;
        tick();
        rst = 1; tick(); rst = 0;
        check("rst_req_req", bus.o_req, 0);
        check("rst_req_state", bus.o_state, 0);
        check("rst_req_drop", bus.o_drop_cnt, 0);

        bus.i_disp_vsync = 1; repeat (300) tick(); bus.i_disp_vsync = 0;
        check("und_sat", bus.o_underrun_cnt, stats_on ? 255 : 0);
        check("und_req", bus.o_req, 0);

        for (int i = 0; i < 20000; i++) begin
            bus.i_cam_sof    = ($urandom_range(0, 79) == 0);
            bus.i_disp_vsync = ($urandom_range(0, 29) == 0);
            bus.i_pix_wr     = ($urandom_range(0, 9) < 7);
            bus.i_pix_rd     = ($urandom_range(0, 9) < 7);
            rst              = ($urandom_range(0, 2999) == 0);
            tick();
        end
        bus.i_cam_sof = 0; bus.i_disp_vsync = 0; bus.i_pix_wr = 0; bus.i_pix_rd = 0; rst = 0;
        tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
